// File: rtl/control_trace_recorder.sv
// control_trace_recorder: triggered control-word/ALU trace buffer; TRACE_WRAP_EN keeps the newest DEPTH entries
module control_trace_recorder #(
   parameter int DEPTH = 16,
   parameter int CW    = 42
) (
   input  logic                       Clock,
   input  logic                       Reset,
   input  logic                       Arm,
   input  logic                       Stop,
   input  logic [CW-1:0]              CtrlWord,
   input  logic [7:0]                 ALUOut,
   input  logic [3:0]                 ALUOutFlag,
   input  logic [CW-1:0]              TrigValue,
   input  logic [CW-1:0]              TrigMask,
   input  logic                       Rd_Req,
   output logic                       Rd_Valid,
   output logic [CW+11:0]             Rd_Data,
   output logic [$clog2(DEPTH+1)-1:0] Count,
   output logic                       Armed,
   output logic                       Capturing,
   output logic                       Done,
   output logic                       Overflow
);
   localparam int AW = $clog2(DEPTH);
   localparam int NW = $clog2(DEPTH+1);
   typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;
   state_t state, nxt;
   logic [CW+11:0] mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic wr, rd, clr, trig;
   assign trig = ((CtrlWord ^ TrigValue) & TrigMask) == '0;
   assign Armed = state == ARMED;
   assign Capturing = state == CAPTURE;
   assign Done = state == DONE;
   always_ff @(posedge Clock)
      state <= !Reset ? IDLE : nxt;
   always_comb begin
      nxt = state;
      wr = 1'b0;
      rd = 1'b0;
      clr = 1'b0;
      case (state)
         IDLE: if (Arm) begin
            nxt = ARMED;
            clr = 1'b1;
         end
         ARMED: if (Stop) nxt = IDLE;
            else if (trig) begin
               wr = 1'b1;
               nxt = CAPTURE;
            end
         CAPTURE: if (Stop) nxt = DONE;
            else if (CtrlWord[CW-1]) begin
               wr = 1'b1;
`ifndef TRACE_WRAP_EN
               if (Count == NW'(DEPTH-1)) nxt = DONE;
`endif
            end
         DONE: if (Arm) begin
            nxt = ARMED;
            clr = 1'b1;
         end else rd = Rd_Req && Count != '0;
         default: nxt = IDLE;
      endcase
   end
   always_ff @(posedge Clock)
      if (wr && Reset) mem[wp] <= {ALUOutFlag, ALUOut, CtrlWord};
   always_ff @(posedge Clock)
      if (!Reset) begin
         Count <= '0;
         wp <= '0;
         rp <= '0;
         Rd_Valid <= 1'b0;
         Rd_Data <= '0;
`ifdef TRACE_WRAP_EN
         Overflow <= 1'b0;
`endif
      end else begin
         Rd_Valid <= rd;
         if (clr) begin
            Count <= '0;
            wp <= '0;
            rp <= '0;
`ifdef TRACE_WRAP_EN
            Overflow <= 1'b0;
`endif
         end else if (rd) begin
            Rd_Data <= mem[rp];
            rp <= rp + 1'b1;
            Count <= Count - 1'b1;
         end else if (wr) begin
            wp <= wp + 1'b1;
`ifdef TRACE_WRAP_EN
            // full buffer: the write lands on the oldest entry, so the read side moves past it
            if (Count == NW'(DEPTH)) begin
               rp <= rp + 1'b1;
               Overflow <= 1'b1;
            end else Count <= Count + 1'b1;
`else
            Count <= Count + 1'b1;
`endif
         end
      end
`ifndef TRACE_WRAP_EN
   assign Overflow = 1'b0;
`endif
endmodule
